// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated write FIFO.
// Bytes are queued from the peripheral bus and serialised onto tx as
// start / data (LSB first) / optional parity / stop bits. While hold is
// high no new frame is started, but the frame in flight always completes
// and writes are still queued.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_BITS-1:0]        wr_data,
    input  logic                        hold,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        busy,
    output logic                        tx
);

    // Clock cycles per bit, rounded to nearest.
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(DIV);

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(DIV - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam bit             PAR_EN    = (PARITY != 0);

    // Parameter sanity checks, evaluated at elaboration.
    if (DIV < 4) begin : g_bad_div
        $error("uart_tx_fifo: CLK_HZ/BAUD must give at least 4 cycles per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a write when the transmitter pops the
    // head in the same cycle; the freed slot is the one being written.
    assign push     = wr_en && (!full || pop);
    // Flags a dropped write in the very cycle it is presented.
    assign overflow = wr_en && !push;
    assign head     = mem[rptr];

    // Parity of the byte about to be popped, latched alongside it.
    always_comb begin
        head_par = (PARITY == 1) ? ~(^head) : (^head);
    end

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit state machine
    // ------------------------------------------------------------------
    state_t               state,    state_nxt;
    logic [BCW-1:0]       baud_cnt, baud_nxt;
    logic [3:0]           bit_cnt,  bit_nxt;
    logic [DATA_BITS-1:0] shreg,    shreg_nxt;
    logic                 par_bit,  par_nxt;
    logic                 tx_nxt;
    logic                 busy_nxt;
    logic                 bit_end;
    logic                 start_ok;

    // The baud counter restarts on every bit boundary, so there is no
    // accumulated drift across back-to-back frames.
    assign bit_end  = (baud_cnt == BAUD_LAST);
    // hold only matters at the points where a new frame could begin.
    assign start_ok = !empty && !hold;

    // Control registers; tx returns high as soon as reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
        end
    end

    // Shift register and latched parity: data path, not reset.
    always_ff @(posedge clk) begin
        shreg   <= shreg_nxt;
        par_bit <= par_nxt;
    end

    // Next-state, pop request and registered-output values.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        tx_nxt    = tx;
        busy_nxt  = busy;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (start_ok) begin
                    pop       = 1'b1;
                    shreg_nxt = head;
                    par_nxt   = head_par;
                    baud_nxt  = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                end else begin
                    baud_nxt = baud_cnt + BCW'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt = '0;
                        if (PAR_EN) begin
                            state_nxt = PARITY_BIT;
                            tx_nxt    = par_bit;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt   = bit_cnt + 4'(1);
                        tx_nxt    = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BCW'(1);
                end
            end

            PARITY_BIT: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    baud_nxt = baud_cnt + BCW'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt = '0;
                        if (start_ok) begin
                            // Chain straight into the next start bit.
                            pop       = 1'b1;
                            shreg_nxt = head;
                            par_nxt   = head_par;
                            state_nxt = START;
                            tx_nxt    = 1'b0;
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            tx_nxt    = 1'b1;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 4'(1);
                    end
                end else begin
                    baud_nxt = baud_cnt + BCW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 8N2) at
// 10 cycles per bit, scoreboard of expected bytes, cycle-exact line decode.
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 10_000_000;
    localparam int DIV    = 10;
    localparam int ND     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       wr_en   [ND];
    logic [7:0] wr_data [ND];
    logic       hold    [ND];
    wire        full_w  [ND];
    wire        empty_w [ND];
    wire  [4:0] count_w [ND];
    wire        ovf_w   [ND];
    wire        busy_w  [ND];
    wire        tx_w    [ND];

    // dut0: 8N1, dut1: 8E1, dut2: 8O1, dut3: 8N2
    for (genvar g = 0; g < ND; g++) begin : g_dut
        uart_tx_fifo #(
            .CLK_HZ    (CLK_HZ),
            .BAUD      (BAUD),
            .DATA_BITS (8),
            .PARITY    ((g == 1) ? 2 : (g == 2) ? 1 : 0),
            .STOP_BITS ((g == 3) ? 2 : 1),
            .FIFO_DEPTH(16)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[g]),
            .wr_data (wr_data[g]),
            .hold    (hold[g]),
            .full    (full_w[g]),
            .empty   (empty_w[g]),
            .count   (count_w[g]),
            .overflow(ovf_w[g]),
            .busy    (busy_w[g]),
            .tx      (tx_w[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int busy_cnt [ND];
    int ovf_cnt  [ND];
    int txlo_cnt [ND];
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (busy_w[i])   busy_cnt[i] <= busy_cnt[i] + 1;
            if (ovf_w[i])    ovf_cnt[i]  <= ovf_cnt[i] + 1;
            if (tx_w[i] == 1'b0) txlo_cnt[i] <= txlo_cnt[i] + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [7:0] v);
        wr_en[d]   = 1'b1;
        wr_data[d] = v;
        tick();
        wr_en[d]   = 1'b0;
    endtask

    // Reference frame, LSB = start bit, in transmission order.
    function automatic logic [15:0] exp_frame(input logic [8:0] d, input int nb,
                                              input int pm, input int sbits);
        logic [15:0] f;
        int          p;
        logic        x;
        f = '0;
        p = 1;
        x = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f[p] = d[i];
            x    = x ^ d[i];
            p++;
        end
        if (pm != 0) begin
            f[p] = (pm == 1) ? ~x : x;
            p++;
        end
        for (int i = 0; i < sbits; i++) begin
            f[p] = 1'b1;
            p++;
        end
        return f;
    endfunction

    // Waits for a start bit, then samples every cycle of an L-bit frame.
    task automatic get_frame(input int d, input int L, input int tmo,
                             output int scyc, output logic [15:0] bits,
                             output logic shape_ok, output logic got);
        int   w;
        logic v;
        bits     = '0;
        shape_ok = 1'b1;
        got      = 1'b0;
        scyc     = -1;
        w        = 0;
        while (tx_w[d] !== 1'b0 && w < tmo) begin
            tick();
            w++;
        end
        if (tx_w[d] !== 1'b0) return;
        got  = 1'b1;
        scyc = cyc;
        for (int b = 0; b < L; b++) begin
            for (int j = 0; j < DIV; j++) begin
                if (!(b == 0 && j == 0)) tick();
                v = tx_w[d];
                if (j == 0) bits[b] = v;
                else if (v !== bits[b]) shape_ok = 1'b0;
            end
        end
    endtask

    task automatic expect_frame(input int d, input int nb, input int pm, input int sbits,
                                input string tag, output int scyc, output logic [15:0] bits);
        logic       shape_ok;
        logic       got;
        logic [8:0] e;
        int         L;
        L = 1 + nb + ((pm != 0) ? 1 : 0) + sbits;
        get_frame(d, L, 400, scyc, bits, shape_ok, got);
        chk({tag, "_seen"}, {31'b0, got}, 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        if (got) begin
            chk(tag, {16'b0, bits}, {16'b0, exp_frame(e, nb, pm, sbits)});
            chk({tag, "_shape"}, {31'b0, shape_ok}, 32'd1);
        end
    endtask

    // Absolute guard against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int          cw, sc, prev, b0, o0, t0, c0;
        logic [15:0] bits;

        reset = 1'b0;
        for (int i = 0; i < ND; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = '0;
            hold[i]    = 1'b0;
        end
        repeat (3) tick();

        // Reset state
        chk("rst_tx",    {31'b0, tx_w[0]},    32'd1);
        chk("rst_busy",  {31'b0, busy_w[0]},  32'd0);
        chk("rst_count", {27'b0, count_w[0]}, 32'd0);
        chk("rst_empty", {31'b0, empty_w[0]}, 32'd1);
        chk("rst_full",  {31'b0, full_w[0]},  32'd0);
        chk("rst_ovf",   {31'b0, ovf_w[0]},   32'd0);
        @(negedge clk) reset = 1'b1;
        repeat (2) tick();

        // Single byte 0x55, bus data changed right after the write
        sb_q.push_back(9'h055);
        wr(0, 8'h55);
        wr_data[0] = 8'hAA;
        cw = cyc;
        b0 = busy_cnt[0];
        chk("cnt_after_wr", {27'b0, count_w[0]}, 32'd1);
        expect_frame(0, 8, 0, 1, "f55", sc, bits);
        chk("latency", sc - cw, 32'd1);
        tick();
        chk("f55_busy_len", busy_cnt[0] - b0, 32'd100);
        chk("f55_busy_end", {31'b0, busy_w[0]}, 32'd0);
        chk("f55_count_end", {27'b0, count_w[0]}, 32'd0);

        // Fill under hold, 17th write overflows
        hold[0] = 1'b1;
        o0 = ovf_cnt[0];
        t0 = txlo_cnt[0];
        for (int i = 0; i < 17; i++) begin
            wr_en[0]   = 1'b1;
            wr_data[0] = 8'(i);
            if (i < 16) sb_q.push_back(9'(i));
            if (i == 16) begin
                #1;
                chk("full_cnt16",  {27'b0, count_w[0]}, 32'd16);
                chk("full_flag",   {31'b0, full_w[0]},  32'd1);
                chk("ovf_pulse",   {31'b0, ovf_w[0]},   32'd1);
            end
            tick();
        end
        wr_en[0] = 1'b0;
        #1;
        chk("ovf_clear",   {31'b0, ovf_w[0]},   32'd0);
        chk("ovf_cnt_keep",{27'b0, count_w[0]}, 32'd16);
        chk("ovf_one_cyc", ovf_cnt[0] - o0,     32'd1);
        chk("hold_tx_idle", txlo_cnt[0] - t0,   32'd0);

        // Release hold: 16 back-to-back frames
        hold[0] = 1'b0;
        c0 = cyc;
        b0 = busy_cnt[0];
        prev = 0;
        for (int k = 0; k < 16; k++) begin
            expect_frame(0, 8, 0, 1, "burst", sc, bits);
            if (k == 0) chk("burst_lat", sc - c0, 32'd1);
            else        chk("b2b_gap", sc - prev, 32'd100);
            prev = sc;
        end
        tick();
        chk("burst_busy_len", busy_cnt[0] - b0, 32'd1600);
        chk("burst_busy_end", {31'b0, busy_w[0]}, 32'd0);
        chk("burst_empty",    {31'b0, empty_w[0]}, 32'd1);

        // Even parity, 0x07
        sb_q.push_back(9'h007);
        wr(1, 8'h07);
        b0 = busy_cnt[1];
        expect_frame(1, 8, 2, 1, "par_even", sc, bits);
        chk("par_even_bit", {31'b0, bits[9]}, 32'd1);
        tick();
        chk("par_even_len", busy_cnt[1] - b0, 32'd110);

        // Odd parity, 0x07
        sb_q.push_back(9'h007);
        wr(2, 8'h07);
        b0 = busy_cnt[2];
        expect_frame(2, 8, 1, 1, "par_odd", sc, bits);
        chk("par_odd_bit", {31'b0, bits[9]}, 32'd0);
        tick();
        chk("par_odd_len", busy_cnt[2] - b0, 32'd110);

        // Two stop bits, hold raised mid-frame with another byte queued
        sb_q.push_back(9'h0FF);
        wr(3, 8'hFF);
        b0 = busy_cnt[3];
        fork
            expect_frame(3, 8, 0, 2, "stop2", sc, bits);
            begin
                repeat (50) tick();
                sb_q.push_back(9'h0A5);
                wr(3, 8'hA5);
                hold[3] = 1'b1;
            end
        join
        chk("stop2_tail", {30'b0, bits[10:9]}, 32'd3);
        tick();
        chk("stop2_len",  busy_cnt[3] - b0, 32'd110);
        chk("stop2_idle", {31'b0, busy_w[3]}, 32'd0);
        chk("stop2_held", {27'b0, count_w[3]}, 32'd1);
        t0 = txlo_cnt[3];
        repeat (20) tick();
        chk("stop2_hold_quiet", txlo_cnt[3] - t0, 32'd0);
        hold[3] = 1'b0;
        expect_frame(3, 8, 0, 2, "after_hold", sc, bits);
        tick();

        // Reset in the middle of a frame, two more bytes queued
        wr(0, 8'h30);
        wr(0, 8'h31);
        wr(0, 8'h32);
        repeat (34) tick();
        chk("mid_busy",  {31'b0, busy_w[0]},  32'd1);
        chk("mid_tx",    {31'b0, tx_w[0]},    32'd0);
        chk("mid_count", {27'b0, count_w[0]}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("arst_tx",    {31'b0, tx_w[0]},    32'd1);
        chk("arst_busy",  {31'b0, busy_w[0]},  32'd0);
        chk("arst_count", {27'b0, count_w[0]}, 32'd0);
        repeat (2) tick();
        @(negedge clk) reset = 1'b1;
        t0 = txlo_cnt[0];
        b0 = busy_cnt[0];
        repeat (300) tick();
        chk("post_rst_tx_quiet", txlo_cnt[0] - t0, 32'd0);
        chk("post_rst_busy",     busy_cnt[0] - b0, 32'd0);
        chk("post_rst_count",    {27'b0, count_w[0]}, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an integrated write FIFO, parity generation, configurable stop bits and a hold gate.
- Next-generation replacement for the MCU's fixed single-byte, button-triggered TX path.
- Sits between the MCU peripheral bus (write side) and the `tx` pin.
- The `hold` input lets a button or software batch bytes before release.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate. DIV = round(CLK_HZ/BAUD) clock cycles per bit. DIV must be at least 4, checked by elaboration assertion.
- DATA_BITS, 8, payload width, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- FIFO_DEPTH, 16, FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- wr_en  input  1  write request, one entry per cycle.
- wr_data  input  DATA_BITS  byte to enqueue.
- hold  input  1  while 1, no new frame starts.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- count  output  $clog2(FIFO_DEPTH)+1  number of entries held.
- overflow  output  1  one-cycle pulse when a write is dropped.
- busy  output  1  1 while a frame is on the line.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, overflow=0, count=0, empty=1, full=0.
  - FIFO pointers cleared; FSM goes to IDLE; baud and bit counters cleared.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The partial frame and all FIFO contents are discarded.
- Write acceptance:
  - A write is accepted when wr_en=1 and either full=0 or a pop occurs in the same cycle.
  - Otherwise the data is dropped, overflow=1 for that cycle, and the FIFO is unchanged.
  - count updates on the edge after acceptance.
  - A simultaneous push and pop leaves count unchanged.
- FIFO: circular buffer; read/write pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
  - IDLE: tx=1, busy=0. If empty=0 and hold=0: pop the head into the shift register, go to START, and drive tx=0 and busy=1 on the same edge.
  - START: hold for DIV cycles, then go to DATA.
  - DATA: shift out LSB first, one bit per DIV cycles, DATA_BITS bits. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: one bit for DIV cycles. Odd mode sends ~^data; even mode sends ^data.
  - STOP: tx=1 for STOP_BITS*DIV cycles. At completion:
    - if empty=0 and hold=0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE and drop busy.
- Latency: with the FSM in IDLE and hold=0, a write accepted at edge N produces tx falling at edge N+1.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles.
- hold:
  - sampled only at frame-start decision points;
  - asserting hold mid-frame never truncates the current frame;
  - writes are still accepted while hold=1.
- Baud counter restarts at 0 on every bit boundary; there is no drift across back-to-back frames.
- wr_data is captured at write time; later changes on the bus do not affect queued data.

Test Plan:
All scenarios use CLK_HZ=100_000_000 and BAUD=10_000_000 (DIV=10), with defaults unless noted.
- Single byte: write 0x55 at edge N.
  - tx=0 over [N+1, N+11).
  - Data bits 1,0,1,0,1,0,1,0, each 10 cycles.
  - Stop high 10 cycles; busy high exactly 100 cycles; count returns to 0.
- Parity: PARITY=2, write 0x07 → parity bit=1, frame 110 cycles. PARITY=1, write 0x07 → parity bit=0.
- Overflow: hold=1, write 17 bytes 0x00..0x10 on consecutive cycles.
  - full=1 and count=16 after the 16th write.
  - The 17th write pulses overflow for 1 cycle; count stays 16; tx stays 1 throughout.
- Release hold after the overflow fill: 16 frames 0x00..0x0F sent back-to-back.
  - busy stays continuously high for 1600 cycles.
  - Each start bit immediately follows the previous stop bit.
- STOP_BITS=2, write 0xFF → tx high for the final 20 cycles of a 110-cycle frame. Set hold=1 mid-frame → the frame completes normally.
- Reset mid-frame: queue 3 bytes, assert reset=0 at cycle 35 of the first frame.
  - tx=1 and busy=0 immediately; count=0.
  - After release, no further frames are sent.
